bus_encoder: RTL and testbench
==============================

// Module: bus_encoder
// PURPOSE
//   Bus-side encoder: turns the datapath's one-hot register drive requests (Rout-style lines)
//   into the registered binary select that steers the 32-bit bus multiplexer.
//   Detects multiple simultaneous drivers, blocks the bus select while a fault is pending,
//   and keeps a saturating count of conflict cycles for debug.
//   Sits between the control unit's out-strobes and the bus mux select input.
// PARAMETERS
//   N       24  number of bus sources (drive_req width); must satisfy N <= 2**SEL_W
//   SEL_W   5   select width; source i is encoded as code i (plain binary index)
//   CNT_W   8   width of conflict counter err_count
// PORTS
//   clk        in   1      system clock, all state updates on rising edge
//   clr        in   1      asynchronous active-high reset
//   drive_req  in   N      one-hot drive requests; bit i = source i wants the bus
//   err_clr    in   1      synchronous fault acknowledge / counter clear
//   sel        out  SEL_W  registered bus mux select
//   sel_valid  out  1      sel names exactly one legal driver this cycle
//   fault      out  1      high while in FAULT state (multi-driver seen, not yet cleared)
//   err_count  out  CNT_W  saturating count of cycles in which >1 request was sampled
// BEHAVIOUR
//   Reset (clr=1, async): sel=0, sel_valid=0, fault=0, err_count=0, state=IDLE.
//   Per edge, classify drive_req: NONE (all 0), ONE (exactly one bit), MULTI (>=2 bits).
//   Latency: one cycle; drive_req sampled at edge k is reflected in outputs after edge k.
//   States (fault = (state==FAULT)):
//     IDLE : NONE->IDLE; ONE->DRIVE; MULTI->FAULT.
//     DRIVE: NONE->IDLE; ONE->DRIVE; MULTI->FAULT.
//     FAULT: err_clr=0 -> FAULT regardless of drive_req.
//            err_clr=1 -> next state by this cycle's class (NONE->IDLE, ONE->DRIVE, MULTI->FAULT).
//   Output update on entering/staying in:
//     DRIVE: sel <= index of set bit, sel_valid <= 1.
//     IDLE : sel holds last value, sel_valid <= 0.
//     FAULT: sel <= index of lowest set bit on entry (MULTI edge), held afterwards; sel_valid <= 0.
//   Control must not drive the bus mux with sel while sel_valid=0; the block never
//     asserts sel_valid on a MULTI cycle.
//   err_count: err_clr=1 clears to 0 on that edge, else +1 on every MULTI cycle (any state),
//     saturating at 2**CNT_W-1 (no wrap).
//     If err_clr=1 and MULTI on the same edge, result is 1 and state stays/enters FAULT.
//   Bits of drive_req are all legal inputs; popcount uses the full N bits.
//   err_clr in IDLE/DRIVE: clears err_count only; no other effect.
//   clr asserted mid-operation: outputs return to reset values immediately (async).
//     First edge after clr release evaluates drive_req normally from IDLE.
//   No combinational path from drive_req to any output.
// TESTING
//   1 Reset: pulse clr mid-cycle with drive_req=24'h000010 -> sel=0,sel_valid=0,fault=0,err_count=0 at once.
//   2 Single driver: drive_req=1<<13 one cycle -> after that edge sel=13, sel_valid=1.
//     Next cycle drive_req=0 -> sel=13 held, sel_valid=0.
//   3 Sweep i=0..23 one-hot back-to-back -> sel=i, sel_valid=1 each cycle, one-cycle lag, fault=0 throughout.
//   4 Conflict: drive_req=(1<<5)|(1<<17) -> fault=1, sel=5, sel_valid=0, err_count=1.
//     Then drive_req=1<<2 without err_clr -> still FAULT, sel=5, err_count=1.
//     Then err_clr=1 with drive_req=1<<2 -> DRIVE, sel=2, sel_valid=1, err_count=0.
//   5 Saturation: hold drive_req=24'hFFFFFF for 300 cycles -> err_count stops at 255, fault=1, sel=0.
//     Then err_clr=1 with drive_req still all ones -> err_count=1, fault=1.
//   6 Async reset in FAULT with err_count=7 -> all outputs reset without a clock edge.
//     First edge after release with drive_req=1<<23 -> sel=23, sel_valid=1.

Source files
------------

// File: rtl/bus_encoder_if.sv
// Bus encoder interface: groups the drive request / select bundle that runs
// between the control unit and the bus multiplexer select logic.
//   drive_req  : one-hot drive requests, bit i = source i wants the bus
//   err_clr    : synchronous fault acknowledge / conflict counter clear
//   sel        : registered bus mux select
//   sel_valid  : sel names exactly one legal driver
//   fault      : multi-driver fault pending
//   err_count  : saturating count of conflict cycles
// master modport = control side, slave modport = encoder.
interface bus_encoder_if #(
    parameter int N     = 24,
    parameter int SEL_W = 5,
    parameter int CNT_W = 8
);
    logic [N-1:0]     drive_req;
    logic             err_clr;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             fault;
    logic [CNT_W-1:0] err_count;

    modport master (
        output drive_req, err_clr,
        input  sel, sel_valid, fault, err_count
    );

    modport slave (
        input  drive_req, err_clr,
        output sel, sel_valid, fault, err_count
    );
endinterface

// File: rtl/bus_encoder.sv
// Bus encoder: converts one-hot register drive requests into the registered
// binary select for the 32-bit bus multiplexer. Two or more simultaneous
// requests put the block into FAULT (select invalid) until err_clr, and every
// multi-driver cycle bumps a saturating debug counter.
// Ports:
//   clk  : system clock, rising edge
//   clr  : asynchronous active-high reset
//   bus  : bus_encoder_if.slave (drive_req, err_clr in; sel, sel_valid,
//          fault, err_count out). All outputs are registered.
module bus_encoder #(
    parameter int N     = 24,
    parameter int SEL_W = 5,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          clr,
    bus_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             req_none;
    logic             req_multi;
    logic [SEL_W-1:0] low_idx;

    // Clearing the lowest set bit leaves something behind only when two or
    // more bits were set, which gives the MULTI class without a popcount.
    assign req_none  = ~|bus.drive_req;
    assign req_multi = |(bus.drive_req & (bus.drive_req - N'(1)));

    // Lowest set bit index; for a ONE cycle this is the only set bit.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.drive_req[i]) begin
                low_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = 1'b0;
        err_count_d = err_count_q;

        // FAULT only re-evaluates the request class once acknowledged.
        if (state_q != FAULT || bus.err_clr) begin
            if (req_multi) begin
                state_d = FAULT;
                // Capture the lowest contender on the MULTI edge; held after.
                sel_d   = low_idx;
            end else if (req_none) begin
                state_d = IDLE;
            end else begin
                state_d     = DRIVE;
                sel_d       = low_idx;
                sel_valid_d = 1'b1;
            end
        end

        // Clear wins over the increment, but a conflict on the clearing edge
        // still counts as one.
        if (bus.err_clr) begin
            err_count_d = req_multi ? CNT_W'(1) : '0;
        end else if (req_multi && !(&err_count_q)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.fault     = (state_q == FAULT);
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_bus_encoder.sv
module tb_bus_encoder;

    localparam int N     = 24;
    localparam int SEL_W = 5;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             sel_valid;
        logic             fault;
        logic [CNT_W-1:0] err_count;
    } obs_t;

    typedef enum int {M_IDLE, M_DRIVE, M_FAULT} mstate_t;

    logic clk;
    logic clr;
    int   checks;
    int   failures;

    bus_encoder_if #(.N(N), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    bus_encoder #(.N(N), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state and scoreboard of expected post-edge outputs.
    mstate_t          m_state;
    logic [SEL_W-1:0] m_sel;
    logic             m_valid;
    logic [CNT_W-1:0] m_cnt;
    obs_t             sb[$];

    function automatic obs_t observe();
        obs_t o;
        o.sel       = bus.sel;
        o.sel_valid = bus.sel_valid;
        o.fault     = bus.fault;
        o.err_count = bus.err_count;
        return o;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_sel   = '0;
        m_valid = 1'b0;
        m_cnt   = '0;
        sb.delete();
    endtask

    // Apply one edge of stimulus to the model and push what the DUT must show.
    task automatic model_step(input logic [N-1:0] req, input logic ec);
        int      ones;
        int      low;
        mstate_t nxt;
        obs_t    e;
        ones = $countones(req);
        low  = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                low = i;
                break;
            end
        end
        if (m_state == M_FAULT && !ec)
            nxt = M_FAULT;
        else if (ones == 0)
            nxt = M_IDLE;
        else if (ones == 1)
            nxt = M_DRIVE;
        else
            nxt = M_FAULT;
        if (nxt == M_DRIVE)
            m_sel = low[SEL_W-1:0];
        else if (nxt == M_FAULT && ones >= 2 && (m_state != M_FAULT || ec))
            m_sel = low[SEL_W-1:0];
        m_valid = (nxt == M_DRIVE);
        if (ec)
            m_cnt = (ones >= 2) ? 8'd1 : 8'd0;
        else if (ones >= 2 && m_cnt != 8'd255)
            m_cnt = m_cnt + 8'd1;
        m_state = nxt;
        e.sel       = m_sel;
        e.sel_valid = m_valid;
        e.fault     = (nxt == M_FAULT);
        e.err_count = m_cnt;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, record the expectation, and sample #1 after the edge.
    task automatic step(input logic [N-1:0] req, input logic ec);
        bus.drive_req = req;
        bus.err_clr   = ec;
        model_step(req, ec);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        obs_t e;
        clr = 1'b1;
        bus.drive_req = '0;
        bus.err_clr   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        step(24'h000010, 1'b0);
        o = observe();
        e = sb.pop_front();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_pre: got %h want %h", o, e);
        end
        // Assert clr mid-cycle, well clear of any rising edge.
        #3;
        clr = 1'b1;
        #1;
        model_reset();
        o = observe();
        checks++;
        if (o !== obs_t'(0)) begin
            failures++;
            $display("FAIL reset_async: got %h want %h", o, obs_t'(0));
        end
        #2;
        clr = 1'b0;
    endtask

    task automatic test_single();
        obs_t o;
        obs_t e;
        step(24'h1 << 13, 1'b0);
        o = observe();
        e = sb.pop_front();
        checks++;
        if (o !== e || bus.sel !== 5'd13 || bus.sel_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_drive: got %h want %h (sel 13 valid)", o, e);
        end
        step('0, 1'b0);
        o = observe();
        e = sb.pop_front();
        checks++;
        if (o !== e || bus.sel !== 5'd13 || bus.sel_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_hold: got %h want %h (sel 13 invalid)", o, e);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        obs_t e;
        for (int i = 0; i < N; i++) begin
            step(24'h1 << i, 1'b0);
            o = observe();
            e = sb.pop_front();
            checks++;
            if (o !== e || int'(bus.sel) != i || bus.sel_valid !== 1'b1 || bus.fault !== 1'b0) begin
                failures++;
                $display("FAIL sweep_%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_conflict();
        obs_t o;
        obs_t e;
        step((24'h1 << 5) | (24'h1 << 17), 1'b0);
        o = observe();
        e = sb.pop_front();
        checks++;
        if (o !== e || bus.fault !== 1'b1 || bus.sel !== 5'd5 ||
            bus.sel_valid !== 1'b0 || bus.err_count !== 8'd1) begin
            failures++;
            $display("FAIL conflict_enter: got %h want %h", o, e);
        end
        step(24'h1 << 2, 1'b0);
        o = observe();
        e = sb.pop_front();
        checks++;
        if (o !== e || bus.fault !== 1'b1 || bus.sel !== 5'd5 || bus.err_count !== 8'd1) begin
            failures++;
            $display("FAIL conflict_hold: got %h want %h", o, e);
        end
        step(24'h1 << 2, 1'b1);
        o = observe();
        e = sb.pop_front();
        checks++;
        if (o !== e || bus.fault !== 1'b0 || bus.sel !== 5'd2 ||
            bus.sel_valid !== 1'b1 || bus.err_count !== 8'd0) begin
            failures++;
            $display("FAIL conflict_ack: got %h want %h", o, e);
        end
    endtask

    task automatic test_saturation();
        obs_t o;
        obs_t e;
        for (int c = 0; c < 300; c++) begin
            step(24'hFFFFFF, 1'b0);
            o = observe();
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL sat_cycle_%0d: got %h want %h", c, o, e);
            end
        end
        checks++;
        if (bus.err_count !== 8'd255 || bus.fault !== 1'b1 || bus.sel !== 5'd0) begin
            failures++;
            $display("FAIL sat_final: got cnt=%0d fault=%0b sel=%0d want cnt=255 fault=1 sel=0",
                     bus.err_count, bus.fault, bus.sel);
        end
        step(24'hFFFFFF, 1'b1);
        o = observe();
        e = sb.pop_front();
        checks++;
        if (o !== e || bus.err_count !== 8'd1 || bus.fault !== 1'b1) begin
            failures++;
            $display("FAIL sat_clr_multi: got %h want %h", o, e);
        end
    endtask

    task automatic test_async_in_fault();
        obs_t o;
        obs_t e;
        step('0, 1'b1);
        void'(sb.pop_front());
        for (int c = 0; c < 7; c++) begin
            step(24'h000003, 1'b0);
            void'(sb.pop_front());
        end
        checks++;
        if (bus.fault !== 1'b1 || bus.err_count !== 8'd7) begin
            failures++;
            $display("FAIL fault_setup: got fault=%0b cnt=%0d want fault=1 cnt=7",
                     bus.fault, bus.err_count);
        end
        #3;
        clr = 1'b1;
        #1;
        model_reset();
        o = observe();
        checks++;
        if (o !== obs_t'(0)) begin
            failures++;
            $display("FAIL fault_async_reset: got %h want %h", o, obs_t'(0));
        end
        #2;
        clr = 1'b0;
        step(24'h1 << 23, 1'b0);
        o = observe();
        e = sb.pop_front();
        checks++;
        if (o !== e || bus.sel !== 5'd23 || bus.sel_valid !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_drive: got %h want %h", o, e);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_conflict();
        test_saturation();
        test_async_in_fault();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
